// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It inhibits the clock, requests to send, shifts out an
// 11-bit frame on device clock falls, then checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       rxInhibit,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkDrive,
    output logic       ps2DataDrive
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE, ERR} state_t;

    state_t          state, state_n;
    logic            clk_meta, clk_sync, clk_prev;
    logic            data_meta, data_sync;
    logic [9:0]      frame;
    logic [3:0]      bit_cnt;
    logic [IW-1:0]   inh_cnt;
    logic [TW-1:0]   to_cnt;
    logic            data_drv;
    logic            fall, timeout, watch;

    assign fall    = clk_prev & ~clk_sync;
    assign timeout = (to_cnt == TO_LAST);
    assign watch   = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAITIDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // A fall takes priority over a timeout that would expire in the same cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (txStart) state_n = INHIBIT;
            INHIBIT:  if (inh_cnt == INH_LAST) state_n = REQ;
            REQ: begin
                if (fall)         state_n = SEND;
                else if (timeout) state_n = ERR;
            end
            SEND: begin
                if (fall) begin
                    if (bit_cnt == 4'd9) state_n = ACK;
                end else if (timeout) begin
                    state_n = ERR;
                end
            end
            ACK: begin
                if (fall)         state_n = data_sync ? ERR : WAITIDLE;
                else if (timeout) state_n = ERR;
            end
            WAITIDLE: begin
                if (clk_sync && data_sync) state_n = IDLE;
                else if (timeout)          state_n = ERR;
            end
            ERR:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        rxInhibit    = busy;
        ps2ClkDrive  = (state == INHIBIT);
        ps2DataDrive = data_drv;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            frame     <= '0;
            bit_cnt   <= '0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            data_drv  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            clk_meta  <= ps2ClkIn;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2DataIn;
            data_sync <= data_meta;

            // Pulses land in the first IDLE cycle, so busy is already low.
            done  <= (state == WAITIDLE) && (state_n == IDLE);
            error <= (state == ERR);

            inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;

            if (!watch || fall)  to_cnt <= '0;
            else if (!timeout)   to_cnt <= to_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (txStart) begin
                        frame   <= {1'b1, ~^txData, txData};
                        bit_cnt <= '0;
                    end
                end
                INHIBIT: if (state_n == REQ) data_drv <= 1'b1;
                SEND: begin
                    if (fall) begin
                        data_drv <= ~frame[0];
                        frame    <= {1'b0, frame[9:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (state_n == ERR || state_n == IDLE) data_drv <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device model clocks frames on the open-drain bus and
// answers with ACK, no ACK, silence or a stall.
module tb_ps2_host_tx;
    localparam int INH  = 5000;
    localparam int TO   = 1000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txStart = 1'b0;
    logic       busy, done, error, rxInhibit;
    logic       ps2ClkIn, ps2DataIn, ps2ClkDrive, ps2DataDrive;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2ClkIn  = ~(ps2ClkDrive | dev_clk_low);
    assign ps2DataIn = ~(ps2DataDrive | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .txData(txData), .txStart(txStart),
        .busy(busy), .done(done), .error(error), .rxInhibit(rxInhibit),
        .ps2ClkIn(ps2ClkIn), .ps2DataIn(ps2DataIn),
        .ps2ClkDrive(ps2ClkDrive), .ps2DataDrive(ps2DataDrive)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, done_cyc = 0, err_cyc = 0, bad_cyc = 0, err_stamp = 0;

    // Pulse counters plus invariant watch: no pulse while busy or driving, never both pulses.
    always @(negedge clk) begin
        cyc++;
        if (done) done_cyc++;
        if (error) begin
            err_cyc++;
            err_stamp = cyc;
        end
        if ((done || error) && (busy || ps2ClkDrive || ps2DataDrive)) bad_cyc++;
        if (done && error) bad_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_inhibit(input logic [7:0] d, input string tag);
        int n;
        txData  = d;
        txStart = 1'b1;
        tick(1);
        txStart = 1'b0;
        chk({tag, ".busy"}, {31'd0, busy}, 1);
        n = 0;
        while (ps2ClkDrive && n < INH + 100) begin
            n++;
            tick(1);
        end
        chk({tag, ".inhibit_len"}, n, INH);
        chk({tag, ".start_drive"}, {31'd0, ps2DataDrive}, 1);
    endtask

    // Device samples the line at the end of each low phase, i.e. just before its rising edge.
    task automatic device(input int pulses, input bit ack, input bit poke, output logic [10:0] bits);
        bits = '0;
        tick(10);
        for (int k = 0; k < pulses; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                tick(2);
            end
            dev_clk_low = 1'b1;
            tick(HALF);
            if (k == 3 && poke) begin
                txData  = 8'h00;
                txStart = 1'b1;
                tick(1);
                txStart = 1'b0;
            end
            if (k < 11) bits[k] = ps2DataIn;
            dev_clk_low = 1'b0;
            tick(HALF);
            if (k == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic full_frame(input logic [7:0] d, input logic [10:0] exp_bits,
                              input bit ack, input bit poke, input string tag);
        logic [10:0] bits;
        int d0, e0;
        d0 = done_cyc;
        e0 = err_cyc;
        run_inhibit(d, tag);
        device(12, ack, poke, bits);
        chk({tag, ".bits"}, {21'd0, bits}, {21'd0, exp_bits});
        tick(50);
        chk({tag, ".done"}, done_cyc - d0, ack ? 1 : 0);
        chk({tag, ".error"}, err_cyc - e0, ack ? 0 : 1);
        chk({tag, ".idle"}, {29'd0, busy, ps2ClkDrive, ps2DataDrive}, 0);
    endtask

    initial begin
        logic [10:0] bits;
        int d0, e0, t0, n;

        // Reset, with a txStart held during it that must be lost.
        rst     = 1'b0;
        txStart = 1'b1;
        tick(3);
        txStart = 1'b0;
        chk("reset.outs", {26'd0, busy, done, error, rxInhibit, ps2ClkDrive, ps2DataDrive}, 0);
        rst = 1'b1;
        tick(2);
        chk("post_reset.outs", {26'd0, busy, done, error, rxInhibit, ps2ClkDrive, ps2DataDrive}, 0);

        // Frame bits {stop, parity, data, start} with hand-computed odd parity.
        full_frame(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1, 1'b0, "ed");
        full_frame(8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b0, "x00");
        full_frame(8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 1'b0, "xff");
        full_frame(8'h01, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1, 1'b0, "x01");
        full_frame(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 1'b0, "noack");
        full_frame(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1, 1'b1, "poke");

        // Device never clocks after the request.
        d0 = done_cyc;
        e0 = err_cyc;
        run_inhibit(8'hA5, "tmo");
        t0 = cyc;
        n = 0;
        while (err_cyc == e0 && n < 3000) begin
            n++;
            tick(1);
        end
        chk("tmo.error", err_cyc - e0, 1);
        chk("tmo.latency_ok", {31'd0, (err_stamp - t0 >= 990) && (err_stamp - t0 <= 1010)}, 1);
        chk("tmo.done", done_cyc - d0, 0);
        tick(2);
        chk("tmo.idle", {29'd0, busy, ps2ClkDrive, ps2DataDrive}, 0);

        // Device stalls after start plus four data bits; 8'h3C LSB-first gives 0,0,1,1.
        d0 = done_cyc;
        e0 = err_cyc;
        run_inhibit(8'h3C, "stall");
        device(5, 1'b0, 1'b0, bits);
        chk("stall.bits", {27'd0, bits[4:0]}, 32'b11000);
        tick(1500);
        chk("stall.error", err_cyc - e0, 1);
        chk("stall.done", done_cyc - d0, 0);
        chk("stall.idle", {29'd0, busy, ps2ClkDrive, ps2DataDrive}, 0);

        // Reset in the middle of the data bits, then a clean frame.
        run_inhibit(8'hED, "rstm");
        device(6, 1'b0, 1'b0, bits);
        chk("rstm.driving", {31'd0, busy}, 1);
        rst = 1'b0;
        tick(1);
        chk("rstm.released", {29'd0, busy, ps2ClkDrive, ps2DataDrive}, 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        full_frame(8'h01, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1, 1'b0, "after_rst");

        chk("invariants", bad_cyc, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (LED set, reset, typematic, ...) from the CPU side to the keyboard.
- It is the opposite direction of the PS/2 keyboard receiver inside the interrupt controller.
- It shares the open-drain ps2CLK/ps2DATA lines; the top level drives each pin low while the matching drive output is 1, else high-Z.
- It asserts rxInhibit while active so the receiver ignores its own frame.

Parameters:
- INHIBIT_CYCLES, 5000, clock-low inhibit duration in clk cycles (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max clk cycles allowed between device clock edges, and for the wait for the first edge (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock (fastClk domain).
- rst  in  1  synchronous reset, active-low.
- txData  in  8  command byte, sampled when txStart is accepted.
- txStart  in  1  one-cycle request; accepted only when busy=0.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- done  out  1  one-cycle pulse on successful ACK completion.
- error  out  1  one-cycle pulse on timeout or missing ACK.
- rxInhibit  out  1  equals busy.
- ps2ClkIn  in  1  raw ps2CLK pin level (asynchronous).
- ps2DataIn  in  1  raw ps2DATA pin level (asynchronous).
- ps2ClkDrive  out  1  1 = pull ps2CLK low.
- ps2DataDrive  out  1  1 = pull ps2DATA low.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, error, ps2ClkDrive and ps2DataDrive are all 0.
  - Synchronizers are set to 1.
  - Counters are cleared.
  - Reset mid-frame releases both lines on the next clk edge.
- Input sync: ps2ClkIn and ps2DataIn each pass through a 2-FF synchronizer plus a previous-value register.
- Falling edge (fall): prevClk=1 and syncClk=0. It is detected 3 clk cycles after the pin transition.
- Frame byte: shift register {stop=1, parity=~^txData, txData}, sent LSB first. Odd parity: for txData=8'h00 the parity bit is 1.
- State machine:
  - IDLE: txStart=1 latches the frame and goes to INHIBIT. busy=1 from the next cycle. txStart while busy is ignored.
  - INHIBIT: ps2ClkDrive=1 for exactly INHIBIT_CYCLES cycles. In the last cycle, ps2DataDrive is set to 1 (start bit = 0). Then go to REQ.
  - REQ: ps2ClkDrive=0 and ps2DataDrive=1. Wait for fall, with timeout.
  - SEND: on each fall, drive the next frame bit: ps2DataDrive = ~bit.
    - Falls 1..8 drive data bits 0..7.
    - Fall 9 drives parity.
    - Fall 10 drives stop (released, ps2DataDrive=0).
    - Bit counter is 4 bits, 0..10.
  - ACK: on fall 11, sample syncData.
    - 0 means acknowledged; go to WAITIDLE.
    - 1 means no acknowledge; go to ERR.
  - WAITIDLE: wait until syncClk=1 and syncData=1 (device released the bus), with timeout. Then pulse done and go to IDLE.
  - ERR: release both lines, pulse error for 1 cycle, go to IDLE.
- Timeout:
  - Counter reloads to 0 on entering REQ and on every fall in REQ/SEND/ACK/WAITIDLE.
  - Reaching TIMEOUT_CYCLES-1 goes to ERR.
  - The counter is wide enough for TIMEOUT_CYCLES; it saturates and never wraps.
- Invariants:
  - done and error are never both 1.
  - ps2ClkDrive=1 only in INHIBIT.
  - busy drops in the same cycle that done/error pulses are visible.
- Simultaneous txStart with reset: reset wins.

Test Plan:
- Reset sequence: rst=0 for 3 cycles, then 1 -> all outputs 0, lines released, busy=0.
- Normal send 8'hED, device model ACKs:
  - ps2ClkDrive high for exactly 5000 cycles.
  - Device model samples on rising edges: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK 0 -> done pulses once; busy falls; error stays 0.
- Send 8'h00 -> parity bit 1. Send 8'hFF -> parity bit 1. Send 8'h01 -> parity bit 0.
- No ACK: device leaves data high on the 11th clock -> error one-cycle pulse, done=0, both drives 0.
- Timeout: device never clocks after the request (TIMEOUT_CYCLES=1000 in the bench) -> error about 1000 cycles after entering REQ; a stall after 4 bits also yields error.
- Abuse cases:
  - txStart pulsed mid-frame -> ignored, the frame is unchanged.
  - rst=0 during SEND bit 5 -> both drives 0 and busy=0 next cycle; a new txStart afterwards sends correctly.
